// File: rtl/csr_pkg.sv
// Shared definitions for the Zicsr access unit: funct3 opcodes, FSM encoding, trap causes.
package csr_pkg;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    localparam int CAUSE_ILLEGAL_INSTR = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE,
        ST_FAULT
    } csr_state_t;

    // funct3 000 and 100 are not CSR operations.
    function automatic logic funct3_legal(input logic [2:0] f3);
        return f3[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write value for CSRRW/S/C and their immediate forms.
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old_val,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] new_val,
    output logic            write_en
);

    logic [XLEN-1:0] src;

    always_comb begin
        src      = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
        // Set/clear with x0 or zimm=0 must not touch the CSR (no side effects).
        write_en = (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
        new_val  = old_val;
        case (funct3[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = old_val;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Execute-stage Zicsr initiator: read phase, write phase, write-back of the old value, illegal traps.
// Optional build macro CSR_RO_CHECK_EN traps writes to read-only CSRs (addr[11:10]==2'b11) locally.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ILLEGAL_CSE = CAUSE_ILLEGAL_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rd_idx,
    input  logic [XLEN-1:0] pc,
    output logic            csr_req,
    output logic            csr_we,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_violation,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal_trap,
    output logic [XLEN-1:0] illegal_pc,
    output logic [XLEN-1:0] illegal_cause
);

    csr_state_t      state;
    logic            ro_fault;

    logic [2:0]      funct3_q;
    logic [4:0]      rs1_idx_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] old_q;

    logic [XLEN-1:0] alu_new;
    logic            alu_we;
    logic            ro_hit;
    logic            accept;

    assign accept = (state == ST_IDLE) && ex_valid && !flush;

    csr_rmw_alu #(.XLEN(XLEN)) u_alu (
        .funct3   (funct3_q),
        .old_val  (csr_rdata),
        .rs1_idx  (rs1_idx_q),
        .rs1_data (rs1_data_q),
        .new_val  (alu_new),
        .write_en (alu_we)
    );

`ifdef CSR_RO_CHECK_EN
    assign ro_hit = (csr_addr_o[11:10] == 2'b11) && alu_we;
`else
    assign ro_hit = 1'b0;
`endif

    // Instruction operands and the read value; only meaningful while the FSM is busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_q   <= funct3;
            rs1_idx_q  <= rs1_idx;
            rs1_data_q <= rs1_data;
            rd_q       <= rd_idx;
            pc_q       <= pc;
        end
        if (state == ST_READ)
            old_q <= csr_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            ro_fault      <= 1'b0;
            ex_ready      <= 1'b1;
            csr_req       <= 1'b0;
            csr_we        <= 1'b0;
            csr_addr_o    <= '0;
            csr_wdata     <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            illegal_trap  <= 1'b0;
            illegal_pc    <= '0;
            illegal_cause <= '0;
        end else begin
            csr_req       <= 1'b0;
            csr_we        <= 1'b0;
            csr_wdata     <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            illegal_trap  <= 1'b0;
            illegal_pc    <= '0;
            illegal_cause <= '0;
            ro_fault      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        csr_addr_o <= csr_addr;
                        if (!funct3_legal(funct3)) begin
                            state         <= ST_FAULT;
                            illegal_trap  <= 1'b1;
                            illegal_pc    <= pc;
                            illegal_cause <= XLEN'(ILLEGAL_CSE);
                            ex_ready      <= 1'b1;
                        end else begin
                            state    <= ST_READ;
                            csr_req  <= 1'b1;
                            ex_ready <= 1'b0;
                        end
                    end
                end

                ST_READ: begin
                    // A flushed instruction must not trap, so flush wins over a violation.
                    if (flush) begin
                        state    <= ST_IDLE;
                        ex_ready <= 1'b1;
                    end else if (csr_violation) begin
                        state         <= ST_FAULT;
                        illegal_trap  <= 1'b1;
                        illegal_pc    <= pc_q;
                        illegal_cause <= XLEN'(ILLEGAL_CSE);
                        ex_ready      <= 1'b1;
                    end else begin
                        state     <= ST_WRITE;
                        ro_fault  <= ro_hit;
                        csr_req   <= alu_we && !ro_hit;
                        csr_we    <= alu_we && !ro_hit;
                        csr_wdata <= (alu_we && !ro_hit) ? alu_new : '0;
                    end
                end

                ST_WRITE: begin
                    // The write is already on the bus, so flush is not honoured here.
                    if ((csr_req && csr_violation) || ro_fault) begin
                        state         <= ST_FAULT;
                        illegal_trap  <= 1'b1;
                        illegal_pc    <= pc_q;
                        illegal_cause <= XLEN'(ILLEGAL_CSE);
                        ex_ready      <= 1'b1;
                    end else begin
                        state    <= ST_DONE;
                        wb_valid <= (rd_q != 5'd0);
                        wb_rd    <= rd_q;
                        wb_data  <= old_q;
                        ex_ready <= 1'b1;
                    end
                end

                ST_DONE, ST_FAULT: begin
                    state    <= ST_IDLE;
                    ex_ready <= 1'b1;
                end

                default: begin
                    state    <= ST_IDLE;
                    ex_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed table-driven bench for csr_access_unit plus hand sequences for traps, flush and reset.
module tb_csr_access_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            ex_valid;
    logic            ex_ready;
    logic            flush;
    logic [2:0]      funct3;
    logic [11:0]     csr_addr;
    logic [4:0]      rs1_idx;
    logic [XLEN-1:0] rs1_data;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] pc;
    logic            csr_req;
    logic            csr_we;
    logic [11:0]     csr_addr_o;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_violation;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            illegal_trap;
    logic [XLEN-1:0] illegal_pc;
    logic [XLEN-1:0] illegal_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_access_unit #(.XLEN(XLEN), .ILLEGAL_CSE(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .flush         (flush),
        .funct3        (funct3),
        .csr_addr      (csr_addr),
        .rs1_idx       (rs1_idx),
        .rs1_data      (rs1_data),
        .rd_idx        (rd_idx),
        .pc            (pc),
        .csr_req       (csr_req),
        .csr_we        (csr_we),
        .csr_addr_o    (csr_addr_o),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .csr_violation (csr_violation),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .illegal_trap  (illegal_trap),
        .illegal_pc    (illegal_pc),
        .illegal_cause (illegal_cause)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] old;
        logic        we;
        logic [31:0] wdata;
        logic        wbv;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Presents an instruction for one accepting edge; returns at the negedge of the following cycle.
    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                         input logic [31:0] d, input logic [4:0] rd, input logic [31:0] p);
        @(negedge clk);
        funct3 = f3; csr_addr = a; rs1_idx = idx; rs1_data = d; rd_idx = rd; pc = p;
        ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'b001, 12'h340, 5'd1,  32'hDEADBEEF, 5'd5, 32'h1000, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b1};
        vecs[1] = '{3'b010, 12'h300, 5'd0,  32'h0000FFFF, 5'd3, 32'h1004, 32'h00000088, 1'b0, 32'h00000000, 1'b1};
        vecs[2] = '{3'b111, 12'h305, 5'd3,  32'h12345678, 5'd7, 32'h1008, 32'h000000FF, 1'b1, 32'h000000FC, 1'b1};
        vecs[3] = '{3'b010, 12'h300, 5'd2,  32'h00000F00, 5'd0, 32'h100C, 32'h00000088, 1'b1, 32'h00000F88, 1'b0};
        vecs[4] = '{3'b011, 12'h341, 5'd4,  32'h000000F0, 5'd1, 32'h1010, 32'h123456FF, 1'b1, 32'h1234560F, 1'b1};
        vecs[5] = '{3'b101, 12'h340, 5'h1F, 32'h0000AAAA, 5'd2, 32'h1014, 32'h00000005, 1'b1, 32'h0000001F, 1'b1};
        vecs[6] = '{3'b110, 12'h344, 5'h10, 32'h00000000, 5'd9, 32'h1018, 32'h00000003, 1'b1, 32'h00000013, 1'b1};
        vecs[7] = '{3'b001, 12'h340, 5'd0,  32'h00000000, 5'd4, 32'h101C, 32'h00000077, 1'b1, 32'h00000000, 1'b1};
        vecs[8] = '{3'b111, 12'h305, 5'd0,  32'hFFFFFFFF, 5'd6, 32'h1020, 32'h00000044, 1'b0, 32'h00000000, 1'b1};

        reset = 1'b1; ex_valid = 1'b0; flush = 1'b0; funct3 = '0; csr_addr = '0;
        rs1_idx = '0; rs1_data = '0; rd_idx = '0; pc = '0; csr_rdata = '0; csr_violation = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ex_ready", ex_ready, 1'b1);
        chk("rst_csr_req", csr_req, 1'b0);
        chk("rst_csr_we", csr_we, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_trap", illegal_trap, 1'b0);
        chk("rst_wdata", csr_wdata, 32'h0);
        chk("rst_addr_o", csr_addr_o, 12'h0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            csr_rdata = vecs[i].old;
            issue(vecs[i].f3, vecs[i].addr, vecs[i].idx, vecs[i].data, vecs[i].rd, vecs[i].pc);
            chk($sformatf("v%0d_rd_req", i), csr_req, 1'b1);
            chk($sformatf("v%0d_rd_we", i), csr_we, 1'b0);
            chk($sformatf("v%0d_addr", i), csr_addr_o, vecs[i].addr);
            chk($sformatf("v%0d_busy", i), ex_ready, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_wr_req", i), csr_req, vecs[i].we);
            chk($sformatf("v%0d_wr_we", i), csr_we, vecs[i].we);
            if (vecs[i].we)
                chk($sformatf("v%0d_wdata", i), csr_wdata, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].wbv);
            chk($sformatf("v%0d_wb_rd", i), wb_rd, vecs[i].rd);
            chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].old);
            chk($sformatf("v%0d_done_ready", i), ex_ready, 1'b1);
            chk($sformatf("v%0d_no_trap", i), illegal_trap, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_wb_pulse", i), wb_valid, 1'b0);
        end

        // Reserved funct3 encodings trap one cycle after acceptance without touching the CSR file.
        issue(3'b100, 12'h340, 5'd1, 32'h1, 5'd5, 32'h2000);
        chk("f100_trap", illegal_trap, 1'b1);
        chk("f100_pc", illegal_pc, 32'h2000);
        chk("f100_cause", illegal_cause, 32'd2);
        chk("f100_no_req", csr_req, 1'b0);
        chk("f100_ready", ex_ready, 1'b1);
        chk("f100_no_wb", wb_valid, 1'b0);
        @(negedge clk);
        chk("f100_pulse", illegal_trap, 1'b0);
        chk("f100_no_req2", csr_req, 1'b0);
        issue(3'b000, 12'h340, 5'd1, 32'h1, 5'd5, 32'h2004);
        chk("f000_trap", illegal_trap, 1'b1);
        chk("f000_pc", illegal_pc, 32'h2004);
        @(negedge clk);

        // CSR file rejects the read.
        csr_rdata = 32'h55;
        issue(3'b001, 12'h7C0, 5'd1, 32'h9, 5'd5, 32'h3000);
        csr_violation = 1'b1;
        @(negedge clk);
        csr_violation = 1'b0;
        chk("rviol_trap", illegal_trap, 1'b1);
        chk("rviol_pc", illegal_pc, 32'h3000);
        chk("rviol_no_we", csr_we, 1'b0);
        chk("rviol_no_wb", wb_valid, 1'b0);
        @(negedge clk);
        chk("rviol_no_wb2", wb_valid, 1'b0);
        chk("rviol_ready", ex_ready, 1'b1);

        // CSR file rejects the write.
        issue(3'b001, 12'h7C1, 5'd1, 32'h9, 5'd5, 32'h3004);
        @(negedge clk);
        chk("wviol_we", csr_we, 1'b1);
        csr_violation = 1'b1;
        @(negedge clk);
        csr_violation = 1'b0;
        chk("wviol_trap", illegal_trap, 1'b1);
        chk("wviol_pc", illegal_pc, 32'h3004);
        chk("wviol_no_wb", wb_valid, 1'b0);
        @(negedge clk);

        // Flush during the read abandons the instruction.
        issue(3'b001, 12'h340, 5'd1, 32'hABCD, 5'd5, 32'h4000);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_no_req", csr_req, 1'b0);
        chk("flush_no_we", csr_we, 1'b0);
        chk("flush_ready", ex_ready, 1'b1);
        chk("flush_no_trap", illegal_trap, 1'b0);
        @(negedge clk);
        chk("flush_no_wb", wb_valid, 1'b0);
        chk("flush_no_we2", csr_we, 1'b0);

        // Flush in IDLE blocks acceptance.
        ex_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_req", csr_req, 1'b0);
        chk("idle_flush_ready", ex_ready, 1'b1);

        // Asynchronous reset in the write phase.
        issue(3'b001, 12'h340, 5'd1, 32'h1111, 5'd5, 32'h5000);
        @(negedge clk);
        chk("rstw_we_before", csr_we, 1'b1);
        reset = 1'b1;
        #1;
        chk("rstw_we", csr_we, 1'b0);
        chk("rstw_req", csr_req, 1'b0);
        chk("rstw_wdata", csr_wdata, 32'h0);
        chk("rstw_ready", ex_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_idle_req", csr_req, 1'b0);
        chk("rstw_no_wb", wb_valid, 1'b0);

        // Back-to-back: ex_valid held high, write-backs 4 cycles apart.
        csr_rdata = 32'h42;
        @(negedge clk);
        funct3 = 3'b001; csr_addr = 12'h340; rs1_idx = 5'd1; rs1_data = 32'h7; rd_idx = 5'd8; pc = 32'h6000;
        ex_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 8) ex_valid = 1'b0;
            chk($sformatf("b2b_wb_%0d", k), wb_valid, (k == 3 || k == 7));
        end
        @(negedge clk);
        chk("b2b_no_third", csr_req, 1'b0);
        repeat (3) @(negedge clk);

        // Write to a read-only CSR address.
        issue(3'b001, 12'hF11, 5'd1, 32'h1, 5'd5, 32'h7000);
        chk("ro_read_req", csr_req, 1'b1);
        @(negedge clk);
`ifdef CSR_RO_CHECK_EN
        chk("ro_no_we", csr_we, 1'b0);
        chk("ro_no_req", csr_req, 1'b0);
        @(negedge clk);
        chk("ro_trap", illegal_trap, 1'b1);
        chk("ro_pc", illegal_pc, 32'h7000);
        chk("ro_no_we2", csr_we, 1'b0);
        chk("ro_no_wb", wb_valid, 1'b0);
`else
        chk("ro_we", csr_we, 1'b1);
        @(negedge clk);
        chk("ro_wb", wb_valid, 1'b1);
        chk("ro_no_trap", illegal_trap, 1'b0);
`endif
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
